// File: rtl/fixed_point_division_ctrl.sv
// Moore controller sequencing one fixed-point divide on the datapath.
// Ports: clk/rst (sync, active-low), start/ack host handshake,
//   co_cnt/dvz/ov datapath flags in; ld_a, ld_b, init, cnt_clr,
//   cnt_en, iter_en strobes out; busy/done/err/err_code status out.
module fixed_point_division_ctrl #(
    parameter int ITER_MAX = 14,
    parameter int WDOG     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ack,
    input  logic       co_cnt,
    input  logic       dvz,
    input  logic       ov,
    output logic       ld_a,
    output logic       ld_b,
    output logic       init,
    output logic       cnt_clr,
    output logic       cnt_en,
    output logic       iter_en,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CHECK,
        INIT,
        RUN,
        DONE,
        ERR
    } state_t;

    // The watchdog must outlast a nominal run and fit in 5 bits;
    // out-of-range settings are clamped into that window.
    localparam int WDOG_LO = (WDOG > ITER_MAX) ? WDOG : ITER_MAX + 1;
    localparam int WDOG_C  = (WDOG_LO > 31) ? 31 : WDOG_LO;
    localparam logic [4:0] WDOG_LAST = 5'(WDOG_C - 1);

    state_t     state_q, state_d;
    logic [1:0] err_code_q, err_code_d;
    logic [4:0] wdog_q, wdog_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            err_code_q <= 2'b00;
            wdog_q     <= 5'd0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            wdog_q     <= wdog_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        wdog_d     = wdog_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD_A;
                    err_code_d = 2'b00;
                end
            end
            LOAD_A: state_d = LOAD_B;
            LOAD_B: state_d = CHECK;
            CHECK: begin
                if (dvz) begin
                    state_d    = ERR;
                    err_code_d = 2'b01;
                end else begin
                    state_d = INIT;
                end
            end
            INIT: begin
                state_d = RUN;
                wdog_d  = 5'd0;
            end
            RUN: begin
                // Saturating increment; RUN exits before the top anyway.
                if (wdog_q != 5'h1f) begin
                    wdog_d = wdog_q + 5'd1;
                end
                if (ov) begin
                    state_d    = ERR;
                    err_code_d = 2'b10;
                end else if (co_cnt) begin
                    state_d = DONE;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d    = ERR;
                    err_code_d = 2'b11;
                end
            end
            DONE: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        init    = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        iter_en = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        unique case (state_q)
            IDLE: ;
            LOAD_A: begin
                ld_a = 1'b1;
                busy = 1'b1;
            end
            LOAD_B: begin
                ld_b = 1'b1;
                busy = 1'b1;
            end
            CHECK: busy = 1'b1;
            INIT: begin
                init    = 1'b1;
                cnt_clr = 1'b1;
                busy    = 1'b1;
            end
            RUN: begin
                iter_en = 1'b1;
                cnt_en  = 1'b1;
                busy    = 1'b1;
            end
            DONE: done = 1'b1;
            ERR:  err  = 1'b1;
        endcase
    end

    assign err_code = err_code_q;

endmodule
